control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning datapath width (fixed at 8; other values unsupported).
REQ-002 The block SHALL have parameter NUM_REGS, default 4, meaning register-file depth (2-bit register addresses).
REQ-003 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port instr  input  16  instruction: [15:14] alu_op, [13] imm_sel, [12:11] rd, [10:9] rs, [8] reserved, [7:0] imm.
REQ-006 The block SHALL have ports instr_valid (input, 1) and instr_ready (output, 1), meaning the instruction handshake.
REQ-007 The block SHALL have ports alu_a, alu_b (output, 8) and alu_op (output, 2), meaning operands and operation to the ALU (00 ADD, 01 SUB, 10 AND, 11 OR).
REQ-008 The block SHALL have ports alu_result (input, 8), alu_zero (input, 1) and alu_carry (input, 1), meaning combinational ALU response.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse on writeback.
REQ-010 The block SHALL have ports flag_z and flag_c (output, 1), meaning the latched ALU flags.

Function
REQ-011 FSM states: IDLE, DECODE, EXECUTE, WRITEBACK; IDLE->DECODE on instr_valid&&instr_ready; DECODE->EXECUTE->WRITEBACK->IDLE unconditionally.
REQ-012 instr_ready SHALL be 1 only in IDLE; instr is captured into an instruction register on the accepting edge; instr_valid outside IDLE is ignored (held upstream).
REQ-013 DECODE: alu_a <= R[rd]; alu_b <= imm_sel ? imm : R[rs]; alu_op <= instr[15:14]; all registered, held stable through EXECUTE.
REQ-014 EXECUTE: alu_result, alu_zero, alu_carry sampled into result/flag holding registers at the end of the cycle.
REQ-015 WRITEBACK: R[rd] <= held result, flag_z/flag_c <= held flags, done = 1 for exactly this cycle.
REQ-016 Latency: accept edge to done high = 3 cycles; max throughput one instruction per 4 cycles.
REQ-017 rd == rs SHALL read the pre-write value (no forwarding needed; reads precede the write by 2 cycles).
REQ-018 Result width is 8 bits; wrap-around (e.g. 0xFF+0x01=0x00) SHALL be stored as the ALU produced it, with flag_c = alu_carry.
REQ-019 Reserved bit [8] SHALL be ignored.
REQ-020 Register file and flags SHALL change only in WRITEBACK.

Reset
REQ-021 On rst_n low: state IDLE, R[0..3] = 0, alu_a = alu_b = 0, alu_op = 00, flag_z = flag_c = 0, done = 0; instr_ready = 1 after release.
REQ-022 Reset asserted mid-instruction SHALL abort it with no register or flag write and no done pulse.

Configuration
REQ-023 Macro CU_DBG_PORT_EN: when defined, ports dbg_addr (input, 2) and dbg_data (output, 8) SHALL exist, with dbg_data = R[dbg_addr] combinationally; when undefined, neither port exists and behaviour is otherwise identical.

Structure
REQ-024 Shared package cu_pkg SHALL hold the ALU op encodings, the FSM state enum, the instruction field positions and DATA_W.
REQ-025 The register file SHALL be a sub-module reg_file (two async read ports, one sync write port, async active-low clear).

Verification
REQ-026 After reset, issue ADD imm R1,0x05 -> done at cycle +3, R1=0x05, flag_z=0, flag_c=0.
REQ-027 R1=0xFF, ADD imm R1,0x01 -> R1=0x00, flag_z=1, flag_c=1.
REQ-028 R2=0x03, R3=0x05, SUB R2,R3 (reg) -> R2=0xFE, flag_c=1; then AND imm R2,0x0F -> R2=0x0E, flag_c=0.
REQ-029 Hold instr_valid high for two back-to-back instructions -> second accepted exactly 4 cycles after first; instr_ready low in DECODE/EXECUTE/WRITEBACK.
REQ-030 Pulse rst_n low during EXECUTE of OR imm R0,0xAA -> R0 stays 0x00, no done, instr_ready=1 after release.
REQ-031 With CU_DBG_PORT_EN, dbg_addr=1 after REQ-026 -> dbg_data=0x05.

Source files
------------

// File: rtl/control_unit_pkg.sv
// cu_pkg: definitions shared by the control unit and its register file.
// It holds the datapath width, the ALU operation encodings, the FSM state
// encoding and the bit positions of the 16-bit instruction fields.
package cu_pkg;

    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 4;
    localparam int REG_AW   = 2;
    localparam int INSTR_W  = 16;

    // Instruction fields: [15:14] op, [13] imm_sel, [12:11] rd, [10:9] rs,
    // [8] reserved, [7:0] imm
    localparam int OP_MSB      = 15;
    localparam int OP_LSB      = 14;
    localparam int IMM_SEL_BIT = 13;
    localparam int RD_MSB      = 12;
    localparam int RD_LSB      = 11;
    localparam int RS_MSB      = 10;
    localparam int RS_LSB      = 9;
    localparam int RSVD_BIT    = 8;
    localparam int IMM_MSB     = 7;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DECODE    = 2'd1,
        ST_EXECUTE   = 2'd2,
        ST_WRITEBACK = 2'd3
    } state_t;

endpackage

// File: rtl/control_unit_reg_file.sv
// reg_file: small register file for the control unit.
// Two asynchronous read ports, one synchronous write port and an
// asynchronous active-low clear of every entry.
// Optional macro CU_DBG_PORT_EN adds a third asynchronous read port.
// Ports:
//   clk, rst_n              clock and async active-low clear
//   we, waddr, wdata        write port (rising edge)
//   raddr_a/rdata_a         read port A
//   raddr_b/rdata_b         read port B
//   dbg_addr/dbg_data       debug read port (CU_DBG_PORT_EN only)
module reg_file
    import cu_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_b
`ifdef CU_DBG_PORT_EN
    ,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
`endif
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

`ifdef CU_DBG_PORT_EN
    assign dbg_data = mem[dbg_addr];
`endif

endmodule

// File: rtl/control_unit.sv
// control_unit: four-state sequencer (IDLE, DECODE, EXECUTE, WRITEBACK)
// that accepts one 16-bit instruction at a time, presents registered
// operands to an external combinational ALU, latches its response and
// writes the result back into a 4 x 8 register file.
// Optional macro CU_DBG_PORT_EN adds dbg_addr/dbg_data (dbg_data = R[dbg_addr]).
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   instr, instr_valid/ready      instruction handshake (ready only in IDLE)
//   alu_a, alu_b, alu_op          registered ALU operands and operation
//   alu_result/zero/carry         ALU response, sampled in EXECUTE
//   done                          high during WRITEBACK only
//   flag_z, flag_c                ALU flags latched at writeback
module control_unit
    import cu_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_carry,
    output logic              done,
    output logic              flag_z,
    output logic              flag_c
`ifdef CU_DBG_PORT_EN
    ,
    input  logic [1:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
`endif
);

    state_t state, next_state;

    logic              accept;
    logic [1:0]        ir_op;
    logic              ir_sel;
    logic [1:0]        ir_rd;
    logic [1:0]        ir_rs;
    logic [7:0]        ir_imm;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] res_hold;
    logic              z_hold;
    logic              c_hold;
    logic              unused_rsvd;

    // Reserved instruction bit carries no meaning.
    assign unused_rsvd = instr[RSVD_BIT];

    assign accept = instr_valid && instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        instr_ready = 1'b0;
        done        = 1'b0;
        case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    next_state = ST_DECODE;
                end
            end
            ST_DECODE:    next_state = ST_EXECUTE;
            ST_EXECUTE:   next_state = ST_WRITEBACK;
            ST_WRITEBACK: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default:      next_state = ST_IDLE;
        endcase
    end

    // Instruction register and ALU response holding registers are pure data:
    // every use is gated by the FSM, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            ir_op  <= instr[OP_MSB:OP_LSB];
            ir_sel <= instr[IMM_SEL_BIT];
            ir_rd  <= instr[RD_MSB:RD_LSB];
            ir_rs  <= instr[RS_MSB:RS_LSB];
            ir_imm <= instr[IMM_MSB:0];
        end
        if (state == ST_EXECUTE) begin
            res_hold <= alu_result;
            z_hold   <= alu_zero;
            c_hold   <= alu_carry;
        end
    end

    // Operands are captured at the end of DECODE and stay stable through
    // EXECUTE; the register file is read two cycles before any write, so
    // rd == rs naturally sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= 2'b00;
        end else if (state == ST_DECODE) begin
            alu_a  <= rd_val;
            alu_b  <= ir_sel ? ir_imm : rs_val;
            alu_op <= ir_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else if (state == ST_WRITEBACK) begin
            flag_z <= z_hold;
            flag_c <= c_hold;
        end
    end

    reg_file #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .AW       (REG_AW)
    ) u_reg_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (done),
        .waddr    (ir_rd),
        .wdata    (res_hold),
        .raddr_a  (ir_rd),
        .rdata_a  (rd_val),
        .raddr_b  (ir_rs),
        .rdata_b  (rs_val)
`ifdef CU_DBG_PORT_EN
        ,
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
`endif
    );

endmodule
